// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Arbitrates register-file writeback between the ALU and the load unit and
//   tracks pending destination registers in a busy scoreboard.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   alu_valid/rd/data     ALU writeback request; alu_ready = accepted this cycle
//   lsu_valid/rd/data     load writeback request; lsu_ready = accepted this cycle
//   mark_valid, mark_rd   issue stage reserves a destination register
//   flush                 synchronous flush: blocks grants, clears scoreboard
//   rs1_addr, rs2_addr    scoreboard lookup addresses
//   rs1_busy, rs2_busy    busy state of the looked-up registers
//   we, rd_addr, wreg     registered register-file write port
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            mark_valid,
  input  logic [AW-1:0]   mark_rd,
  input  logic            flush,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            we,
  output logic [AW-1:0]   rd_addr,
  output logic [XLEN-1:0] wreg
);

  localparam int NREG = 2 ** AW;

  // 1: the LSU was granted most recently, so the ALU wins the next tie.
  logic            lsu_last_reg;
  logic            we_reg;
  logic [AW-1:0]   rd_addr_reg;
  logic [XLEN-1:0] wreg_reg;
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;

  logic            grant_alu;
  logic            grant_lsu;
  logic            accept;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;

  // Round-robin grant. Ready is also held low while reset is asserted so no
  // requester sees a handshake that the flops are going to discard.
  always_comb begin
    grant_alu = alu_valid && (!lsu_valid || lsu_last_reg);
    grant_lsu = lsu_valid && (!alu_valid || !lsu_last_reg);
    alu_ready = reset_n && !flush && grant_alu;
    lsu_ready = reset_n && !flush && grant_lsu;
    accept    = alu_ready || lsu_ready;
    sel_rd    = lsu_ready ? lsu_rd   : alu_rd;
    sel_data  = lsu_ready ? lsu_data : alu_data;
  end

  // Writeback register stage. A transfer to x0 is consumed but never
  // produces a write, and the address/data hold their previous values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lsu_last_reg <= 1'b1;
      we_reg       <= 1'b0;
      rd_addr_reg  <= '0;
      wreg_reg     <= '0;
    end else begin
      we_reg <= accept && (sel_rd != '0);
      if (accept) begin
        lsu_last_reg <= lsu_ready;
      end
      if (accept && (sel_rd != '0)) begin
        rd_addr_reg <= sel_rd;
        wreg_reg    <= sel_data;
      end
    end
  end

  // Scoreboard next state per register. Priority: flush clears everything,
  // then a new reservation beats a commit to the same register, because the
  // reservation belongs to a younger producer still in flight.
  assign busy_next[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
      assign busy_next[gi] =
        flush                                         ? 1'b0 :
        (mark_valid && (mark_rd == AW'(gi)))          ? 1'b1 :
        (we_reg && (rd_addr_reg == AW'(gi)))          ? 1'b0 :
                                                        busy_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  // Lookups see registered state only; no bypass of same-cycle mark/clear.
  assign rs1_busy = busy_reg[rs1_addr];
  assign rs2_busy = busy_reg[rs2_addr];

  assign we      = we_reg;
  assign rd_addr = rd_addr_reg;
  assign wreg    = wreg_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed, table-driven bench for regfile_wb_arbiter (XLEN=32, AW=5).
//   Each table row is applied for one cycle: ready outputs are checked
//   before the edge, the write port and scoreboard lookups after it.
//   Hand-written sequences cover reset behaviour.
module tb_regfile_wb_arbiter;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            reset_n;
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            mark_valid;
  logic [AW-1:0]   mark_rd;
  logic            flush;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            we;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] wreg;

  int n_cmp;
  int n_bad;

  regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .lsu_valid  (lsu_valid),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .lsu_ready  (lsu_ready),
    .mark_valid (mark_valid),
    .mark_rd    (mark_rd),
    .flush      (flush),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .we         (we),
    .rd_addr    (rd_addr),
    .wreg       (wreg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        mv;
    logic [4:0]  mrd;
    logic        fl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_ar;
    logic        e_lr;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic        e_b1;
    logic        e_b2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic [31:0] adat,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
    input logic mv, input logic [4:0] mrd, input logic fl,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic e_ar, input logic e_lr, input logic e_we,
    input logic [4:0] e_rd, input logic [31:0] e_wd,
    input logic e_b1, input logic e_b2);
    vec_t v;
    v.av = av;   v.ard = ard;   v.adat = adat;
    v.lv = lv;   v.lrd = lrd;   v.ldat = ldat;
    v.mv = mv;   v.mrd = mrd;   v.fl = fl;
    v.rs1 = rs1; v.rs2 = rs2;
    v.e_ar = e_ar; v.e_lr = e_lr; v.e_we = e_we;
    v.e_rd = e_rd; v.e_wd = e_wd; v.e_b1 = e_b1; v.e_b2 = e_b2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    mark_valid = 1'b0; mark_rd = '0; flush = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
    lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ldat;
    mark_valid = v.mv; mark_rd = v.mrd; flush = v.fl;
    rs1_addr = v.rs1; rs2_addr = v.rs2;
    #1;
    chk($sformatf("v%0d alu_ready", idx), 32'(alu_ready), 32'(v.e_ar));
    chk($sformatf("v%0d lsu_ready", idx), 32'(lsu_ready), 32'(v.e_lr));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d we", idx), 32'(we), 32'(v.e_we));
    chk($sformatf("v%0d rd_addr", idx), 32'(rd_addr), 32'(v.e_rd));
    chk($sformatf("v%0d wreg", idx), wreg, v.e_wd);
    chk($sformatf("v%0d rs1_busy", idx), 32'(rs1_busy), 32'(v.e_b1));
    chk($sformatf("v%0d rs2_busy", idx), 32'(rs2_busy), 32'(v.e_b2));
    $display("vec %0d: ar=%0b lr=%0b we=%0b rd=%0d wreg=0x%08h b1=%0b b2=%0b",
             idx, v.e_ar, v.e_lr, we, rd_addr, wreg, rs1_busy, rs2_busy);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    //          av ard  adat           lv lrd ldat     mv mrd fl rs1 rs2 ar lr we rd  wd             b1 b2
    vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,       0, 0, 0, 5, 0,  1, 0, 1, 5, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 3, 32'h33,  0, 0, 0, 3, 0,  0, 1, 1, 3, 32'h33,       0, 0));
    vecs.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22,  0, 0, 0, 1, 2,  1, 0, 1, 1, 32'h11,       0, 0));
    vecs.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22,  0, 0, 0, 1, 2,  0, 1, 1, 2, 32'h22,       0, 0));
    vecs.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22,  0, 0, 0, 1, 2,  1, 0, 1, 1, 32'h11,       0, 0));
    vecs.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22,  0, 0, 0, 1, 2,  0, 1, 1, 2, 32'h22,       0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       0, 0, 0, 0, 0,  0, 0, 0, 2, 32'h22,       0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       1, 7, 0, 7, 5,  0, 0, 0, 2, 32'h22,       1, 0));
    vecs.push_back(mk(0, 0, 0,            1, 7, 32'h77,  0, 0, 0, 7, 0,  0, 1, 1, 7, 32'h77,       1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       0, 0, 0, 7, 0,  0, 0, 0, 7, 32'h77,       0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       1, 7, 0, 7, 0,  0, 0, 0, 7, 32'h77,       1, 0));
    vecs.push_back(mk(0, 0, 0,            1, 7, 32'h78,  0, 0, 0, 7, 0,  0, 1, 1, 7, 32'h78,       1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       1, 7, 0, 7, 0,  0, 0, 0, 7, 32'h78,       1, 0));
    vecs.push_back(mk(1, 0, 32'h1234,     0, 0, 0,       0, 0, 0, 0, 7,  1, 0, 0, 7, 32'h78,       0, 1));
    vecs.push_back(mk(1, 1, 32'hA1,       1, 2, 32'hA2,  0, 0, 0, 0, 7,  0, 1, 1, 2, 32'hA2,       0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       1, 0, 0, 0, 7,  0, 0, 0, 2, 32'hA2,       0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       1, 3, 0, 3, 9,  0, 0, 0, 2, 32'hA2,       1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       1, 9, 0, 3, 9,  0, 0, 0, 2, 32'hA2,       1, 1));
    vecs.push_back(mk(1, 9, 32'h99,       0, 0, 0,       0, 0, 0, 3, 9,  1, 0, 1, 9, 32'h99,       1, 1));
    vecs.push_back(mk(1, 1, 32'hC1,       1, 2, 32'hC2,  1, 4, 1, 3, 9,  0, 0, 0, 9, 32'h99,       0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       0, 0, 0, 7, 4,  0, 0, 0, 9, 32'h99,       0, 0));
    vecs.push_back(mk(1, 1, 32'hB1,       1, 2, 32'hB2,  0, 0, 0, 1, 2,  0, 1, 1, 2, 32'hB2,       0, 0));

    // Initial reset: outputs cleared and readies blocked even with requests.
    reset_n = 1'b0;
    drive_idle();
    alu_valid = 1'b1; alu_rd = 5'd4; lsu_valid = 1'b1; lsu_rd = 5'd6;
    #1;
    chk("rst we", 32'(we), 32'd0);
    chk("rst rd_addr", 32'(rd_addr), 32'd0);
    chk("rst wreg", wreg, 32'd0);
    chk("rst alu_ready", 32'(alu_ready), 32'd0);
    chk("rst lsu_ready", 32'(lsu_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst hold we", 32'(we), 32'd0);
    $display("reset: we=%0b rd=%0d wreg=0x%08h", we, rd_addr, wreg);
    @(negedge clk);
    drive_idle();
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
    end

    // Asynchronous reset in the middle of a cycle with a write presented.
    @(negedge clk);
    drive_idle();
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h0000CAFE;
    mark_valid = 1'b1; mark_rd = 5'd6; rs1_addr = 5'd6;
    @(posedge clk);
    #1;
    chk("pre-rst we", 32'(we), 32'd1);
    chk("pre-rst rd_addr", 32'(rd_addr), 32'd12);
    chk("pre-rst busy6", 32'(rs1_busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async we", 32'(we), 32'd0);
    chk("async rd_addr", 32'(rd_addr), 32'd0);
    chk("async wreg", wreg, 32'd0);
    chk("async busy6", 32'(rs1_busy), 32'd0);
    chk("async alu_ready", 32'(alu_ready), 32'd0);
    $display("async reset: we=%0b rd=%0d wreg=0x%08h busy6=%0b", we, rd_addr, wreg, rs1_busy);

    // Release: pointer back to its reset value, so the ALU wins the tie.
    @(negedge clk);
    reset_n = 1'b1;
    drive_idle();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hD1;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hD2;
    #1;
    chk("post-rst alu_ready", 32'(alu_ready), 32'd1);
    chk("post-rst lsu_ready", 32'(lsu_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("post-rst we", 32'(we), 32'd1);
    chk("post-rst rd_addr", 32'(rd_addr), 32'd1);
    chk("post-rst wreg", wreg, 32'hD1);
    $display("post reset: we=%0b rd=%0d wreg=0x%08h", we, rd_addr, wreg);
    @(negedge clk);
    drive_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
